// File: rtl/nl_flit_sink_monitor.sv
// Flit sink and traffic monitor for one network exit port.
// Reassembles packets per exit VC, returns one credit per received flit, and
// collects delivery statistics once a warm-up number of packets has passed.
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   flit_valid/head/tail/vc  incoming flit control
//   flit_ts/hops/dx/dy       head-only payload: injection time, hop count, destination
//   credit_out               per-VC credit pulse, one cycle after each valid flit
//   rec_count/drop_count     completed packets delivered here / misrouted
//   total_latency/total_hops saturating sums over measured packets
//   min_latency/max_latency  extremes over measured packets
//   proto_err                sticky protocol violation flag
//   meas_done                WARMUP+MEAS packets received
module nl_flit_sink_monitor #(
    parameter int unsigned NV     = 4,
    parameter int unsigned TS_W   = 16,
    parameter int unsigned HOP_W  = 4,
    parameter int unsigned XPOS   = 0,
    parameter int unsigned YPOS   = 0,
    parameter int unsigned XY_W   = 3,
    parameter int unsigned WARMUP = 16,
    parameter int unsigned MEAS   = 64
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   flit_valid,
    input  logic                                   flit_head,
    input  logic                                   flit_tail,
    input  logic [(NV > 1 ? $clog2(NV) : 1)-1:0]   flit_vc,
    input  logic [TS_W-1:0]                        flit_ts,
    input  logic [HOP_W-1:0]                       flit_hops,
    input  logic [XY_W-1:0]                        flit_dx,
    input  logic [XY_W-1:0]                        flit_dy,
    output logic [NV-1:0]                          credit_out,
    output logic [31:0]                            rec_count,
    output logic [31:0]                            drop_count,
    output logic [31:0]                            total_latency,
    output logic [31:0]                            total_hops,
    output logic [TS_W-1:0]                        min_latency,
    output logic [TS_W-1:0]                        max_latency,
    output logic                                   proto_err,
    output logic                                   meas_done
);

    localparam logic [XY_W-1:0] XposV   = XY_W'(XPOS);
    localparam logic [XY_W-1:0] YposV   = XY_W'(YPOS);
    localparam logic [32:0]     WarmCnt = 33'(WARMUP);
    localparam logic [32:0]     DoneCnt = 33'(WARMUP) + 33'(MEAS);

    typedef enum logic [1:0] {StIdle, StRecv, StDrop} vc_state_e;

    vc_state_e        state_q [NV];
    vc_state_e        state_d [NV];
    logic [TS_W-1:0]  ts_q    [NV];
    logic [TS_W-1:0]  ts_d    [NV];
    logic [HOP_W-1:0] hops_q  [NV];
    logic [HOP_W-1:0] hops_d  [NV];

    logic [TS_W-1:0]  sys_time_q;
    logic [NV-1:0]    credit_q, credit_d;
    logic [31:0]      rec_count_q, rec_count_d;
    logic [31:0]      drop_count_q, drop_count_d;
    logic [31:0]      total_latency_q, total_latency_d;
    logic [31:0]      total_hops_q, total_hops_d;
    logic [TS_W-1:0]  min_latency_q, min_latency_d;
    logic [TS_W-1:0]  max_latency_q, max_latency_d;
    logic             proto_err_q, proto_err_d;
    logic             meas_done_q, meas_done_d;

    // Packet completion this cycle and the head fields it carries.
    logic             dest_match;
    logic             cmp_rx;
    logic             cmp_drop;
    logic [TS_W-1:0]  cmp_ts;
    logic [HOP_W-1:0] cmp_hops;
    logic [TS_W-1:0]  cmp_lat;
    logic [32:0]      lat_sum;
    logic [32:0]      hop_sum;

    // Per-VC reassembly.
    always_comb begin
        state_d     = state_q;
        ts_d        = ts_q;
        hops_d      = hops_q;
        proto_err_d = proto_err_q;
        cmp_rx      = 1'b0;
        cmp_drop    = 1'b0;
        cmp_ts      = ts_q[flit_vc];
        cmp_hops    = hops_q[flit_vc];
        dest_match  = (flit_dx == XposV) && (flit_dy == YposV);
        credit_d    = '0;
        if (flit_valid) begin
            credit_d[flit_vc] = 1'b1;
            if (flit_head) begin
                // A head mid-packet abandons the open packet and restarts.
                if (state_q[flit_vc] != StIdle) begin
                    proto_err_d = 1'b1;
                end
                if (flit_tail) begin
                    state_d[flit_vc] = StIdle;
                    cmp_rx           = dest_match;
                    cmp_drop         = !dest_match;
                    cmp_ts           = flit_ts;
                    cmp_hops         = flit_hops;
                end else begin
                    state_d[flit_vc] = dest_match ? StRecv : StDrop;
                    ts_d[flit_vc]    = flit_ts;
                    hops_d[flit_vc]  = flit_hops;
                end
            end else begin
                unique case (state_q[flit_vc])
                    StIdle: proto_err_d = 1'b1;
                    StRecv: begin
                        if (flit_tail) begin
                            state_d[flit_vc] = StIdle;
                            cmp_rx           = 1'b1;
                        end
                    end
                    StDrop: begin
                        if (flit_tail) begin
                            state_d[flit_vc] = StIdle;
                            cmp_drop         = 1'b1;
                        end
                    end
                    default: state_d[flit_vc] = StIdle;
                endcase
            end
        end
    end

    // Counters and statistics.
    always_comb begin
        cmp_lat         = sys_time_q - cmp_ts;
        lat_sum         = {1'b0, total_latency_q} + 33'(cmp_lat);
        hop_sum         = {1'b0, total_hops_q} + 33'(cmp_hops);
        rec_count_d     = rec_count_q;
        drop_count_d    = drop_count_q;
        total_latency_d = total_latency_q;
        total_hops_d    = total_hops_q;
        min_latency_d   = min_latency_q;
        max_latency_d   = max_latency_q;
        if (cmp_drop) begin
            drop_count_d = drop_count_q + 32'd1;
        end
        if (cmp_rx) begin
            rec_count_d = rec_count_q + 32'd1;
            // Measured once this packet's ordinal exceeds the warm-up count.
            if ({1'b0, rec_count_q} + 33'd1 > WarmCnt) begin
                total_latency_d = lat_sum[32] ? '1 : lat_sum[31:0];
                total_hops_d    = hop_sum[32] ? '1 : hop_sum[31:0];
                if (cmp_lat < min_latency_q) begin
                    min_latency_d = cmp_lat;
                end
                if (cmp_lat > max_latency_q) begin
                    max_latency_d = cmp_lat;
                end
            end
        end
        meas_done_d = meas_done_q || ({1'b0, rec_count_d} >= DoneCnt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NV); i++) begin
                state_q[i] <= StIdle;
                ts_q[i]    <= '0;
                hops_q[i]  <= '0;
            end
            sys_time_q      <= '0;
            credit_q        <= '0;
            rec_count_q     <= '0;
            drop_count_q    <= '0;
            total_latency_q <= '0;
            total_hops_q    <= '0;
            min_latency_q   <= '1;
            max_latency_q   <= '0;
            proto_err_q     <= 1'b0;
            meas_done_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            ts_q            <= ts_d;
            hops_q          <= hops_d;
            sys_time_q      <= sys_time_q + 1'b1;
            credit_q        <= credit_d;
            rec_count_q     <= rec_count_d;
            drop_count_q    <= drop_count_d;
            total_latency_q <= total_latency_d;
            total_hops_q    <= total_hops_d;
            min_latency_q   <= min_latency_d;
            max_latency_q   <= max_latency_d;
            proto_err_q     <= proto_err_d;
            meas_done_q     <= meas_done_d;
        end
    end

    assign credit_out    = credit_q;
    assign rec_count     = rec_count_q;
    assign drop_count    = drop_count_q;
    assign total_latency = total_latency_q;
    assign total_hops    = total_hops_q;
    assign min_latency   = min_latency_q;
    assign max_latency   = max_latency_q;
    assign proto_err     = proto_err_q;
    assign meas_done     = meas_done_q;

endmodule

// File: tb/tb_nl_flit_sink_monitor.sv
// Bench for nl_flit_sink_monitor: two instances share stimulus, one with no
// warm-up (WARMUP=0, MEAS=4) and one with WARMUP=2, MEAS=3.
module tb_nl_flit_sink_monitor;

    localparam int NV = 4;
    localparam int XP = 2;
    localparam int YP = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flit_valid = 1'b0;
    logic        flit_head = 1'b0;
    logic        flit_tail = 1'b0;
    logic [1:0]  flit_vc = '0;
    logic [15:0] flit_ts = '0;
    logic [3:0]  flit_hops = '0;
    logic [2:0]  flit_dx = '0;
    logic [2:0]  flit_dy = '0;

    logic [3:0]  credit_a, credit_b;
    logic [31:0] rec_a, drop_a, tlat_a, thop_a, rec_b, drop_b, tlat_b, thop_b;
    logic [15:0] minl_a, maxl_a, minl_b, maxl_b;
    logic        err_a, done_a, err_b, done_b;

    always #5 clk = ~clk;

    nl_flit_sink_monitor #(
        .NV(4), .TS_W(16), .HOP_W(4), .XPOS(XP), .YPOS(YP), .XY_W(3), .WARMUP(0), .MEAS(4)
    ) u_dut_w0 (
        .clk(clk), .rst(rst), .flit_valid(flit_valid), .flit_head(flit_head),
        .flit_tail(flit_tail), .flit_vc(flit_vc), .flit_ts(flit_ts), .flit_hops(flit_hops),
        .flit_dx(flit_dx), .flit_dy(flit_dy), .credit_out(credit_a), .rec_count(rec_a),
        .drop_count(drop_a), .total_latency(tlat_a), .total_hops(thop_a),
        .min_latency(minl_a), .max_latency(maxl_a), .proto_err(err_a), .meas_done(done_a)
    );

    nl_flit_sink_monitor #(
        .NV(4), .TS_W(16), .HOP_W(4), .XPOS(XP), .YPOS(YP), .XY_W(3), .WARMUP(2), .MEAS(3)
    ) u_dut_w2 (
        .clk(clk), .rst(rst), .flit_valid(flit_valid), .flit_head(flit_head),
        .flit_tail(flit_tail), .flit_vc(flit_vc), .flit_ts(flit_ts), .flit_hops(flit_hops),
        .flit_dx(flit_dx), .flit_dy(flit_dy), .credit_out(credit_b), .rec_count(rec_b),
        .drop_count(drop_b), .total_latency(tlat_b), .total_hops(thop_b),
        .min_latency(minl_b), .max_latency(maxl_b), .proto_err(err_b), .meas_done(done_b)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: cycles since reset release, open packets, completed packets.
    int       now;
    bit       m_open  [NV];
    bit       m_match [NV];
    int       m_ts    [NV];
    int       m_hops  [NV];
    int       lat_q[$];
    int       hop_q[$];
    int       m_drop;
    bit       m_err;
    logic [3:0] m_credit;

    always @(posedge clk or posedge rst) begin
        if (rst) now <= 0;
        else     now <= now + 1;
    end

    function automatic void model_clear();
        for (int i = 0; i < NV; i++) begin
            m_open[i] = 1'b0; m_match[i] = 1'b0; m_ts[i] = 0; m_hops[i] = 0;
        end
        lat_q.delete(); hop_q.delete();
        m_drop = 0; m_err = 1'b0; m_credit = '0;
    endfunction

    // Statistics over received packets after skipping the first w.
    function automatic void exp_stats(input int w, output longint slat, output longint shop,
                                      output int mn, output int mx);
        slat = 0; shop = 0; mn = 16'hFFFF; mx = 0;
        for (int i = w; i < lat_q.size(); i++) begin
            slat += lat_q[i]; shop += hop_q[i];
            if (lat_q[i] < mn) mn = lat_q[i];
            if (lat_q[i] > mx) mx = lat_q[i];
        end
        if (slat > 64'hFFFF_FFFF) slat = 64'hFFFF_FFFF;
        if (shop > 64'hFFFF_FFFF) shop = 64'hFFFF_FFFF;
    endfunction

    // Drive one cycle (call at a negedge), update the model, return at the next negedge.
    task automatic put(input bit v, input bit h, input bit t, input int vc, input int tsv,
                       input int hopsv, input bit match);
        int tnow;
        tnow       = now;
        flit_valid = v; flit_head = h; flit_tail = t;
        flit_vc    = 2'(vc); flit_ts = 16'(tsv); flit_hops = 4'(hopsv);
        if (match) begin
            flit_dx = 3'(XP); flit_dy = 3'(YP);
        end else begin
            flit_dx = 3'(XP + 1 + $urandom_range(0, 6)); flit_dy = 3'($urandom);
        end
        m_credit = v ? 4'(1 << vc) : 4'b0;
        if (v) begin
            if (h) begin
                if (m_open[vc]) m_err = 1'b1;
                if (t) begin
                    m_open[vc] = 1'b0;
                    if (match) begin
                        lat_q.push_back((tnow - tsv) & 32'hFFFF); hop_q.push_back(hopsv);
                    end else m_drop++;
                end else begin
                    m_open[vc] = 1'b1; m_match[vc] = match; m_ts[vc] = tsv; m_hops[vc] = hopsv;
                end
            end else if (!m_open[vc]) begin
                m_err = 1'b1;
            end else if (t) begin
                m_open[vc] = 1'b0;
                if (m_match[vc]) begin
                    lat_q.push_back((tnow - m_ts[vc]) & 32'hFFFF); hop_q.push_back(m_hops[vc]);
                end else m_drop++;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) put(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b1);
    endtask

    task automatic do_reset();
        flit_valid = 1'b0;
        rst = 1'b1;
        model_clear();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (credit_a !== 4'b0) begin n_fail++; $display("FAIL rst_credit: got %b want 0000", credit_a); end
        n_cmp++; if (rec_a !== 32'd0) begin n_fail++; $display("FAIL rst_rec: got %0d want 0", rec_a); end
        n_cmp++; if (drop_a !== 32'd0) begin n_fail++; $display("FAIL rst_drop: got %0d want 0", drop_a); end
        n_cmp++; if (tlat_a !== 32'd0) begin n_fail++; $display("FAIL rst_tlat: got %0d want 0", tlat_a); end
        n_cmp++; if (thop_a !== 32'd0) begin n_fail++; $display("FAIL rst_thop: got %0d want 0", thop_a); end
        n_cmp++; if (minl_a !== 16'hFFFF) begin n_fail++; $display("FAIL rst_min: got %h want ffff", minl_a); end
        n_cmp++; if (maxl_a !== 16'd0) begin n_fail++; $display("FAIL rst_max: got %0d want 0", maxl_a); end
        n_cmp++; if ({err_a, done_a, err_b, done_b} !== 4'b0) begin
            n_fail++; $display("FAIL rst_flags: got %b want 0000", {err_a, done_a, err_b, done_b});
        end
    endtask

    task automatic test_basic();
        int pulses;
        do_reset();
        idle(10);
        pulses = 0;
        put(1'b1, 1'b1, 1'b0, 1, 4, 2, 1'b1); pulses += int'(credit_a[1]);
        put(1'b1, 1'b0, 1'b0, 1, 0, 0, 1'b1); pulses += int'(credit_a[1]);
        put(1'b1, 1'b0, 1'b1, 1, 0, 0, 1'b1); pulses += int'(credit_a[1]);
        n_cmp++; if (rec_a !== 32'd1) begin n_fail++; $display("FAIL basic_rec: got %0d want 1", rec_a); end
        n_cmp++; if (tlat_a !== 32'd8) begin n_fail++; $display("FAIL basic_tlat: got %0d want 8", tlat_a); end
        n_cmp++; if (minl_a !== 16'd8 || maxl_a !== 16'd8) begin
            n_fail++; $display("FAIL basic_minmax: got %0d/%0d want 8/8", minl_a, maxl_a);
        end
        n_cmp++; if (thop_a !== 32'd2) begin n_fail++; $display("FAIL basic_thop: got %0d want 2", thop_a); end
        n_cmp++; if (rec_b !== 32'd1 || tlat_b !== 32'd0) begin
            n_fail++; $display("FAIL basic_warm: got rec %0d tlat %0d want 1 0", rec_b, tlat_b);
        end
        idle(1); pulses += int'(credit_a[1]);
        n_cmp++; if (pulses !== 3) begin n_fail++; $display("FAIL basic_credits: got %0d want 3", pulses); end
    endtask

    task automatic test_drop();
        do_reset();
        put(1'b1, 1'b1, 1'b1, 3, 7, 1, 1'b0);
        n_cmp++; if (credit_a !== 4'b1000) begin n_fail++; $display("FAIL drop_credit: got %b want 1000", credit_a); end
        n_cmp++; if (drop_a !== 32'd1 || rec_a !== 32'd0) begin
            n_fail++; $display("FAIL drop_counts: got %0d/%0d want 1/0", drop_a, rec_a);
        end
        idle(1);
        n_cmp++; if (credit_a !== 4'b0) begin n_fail++; $display("FAIL drop_credit_once: got %b want 0000", credit_a); end
    endtask

    task automatic test_wrap();
        do_reset();
        idle(1);
        put(1'b1, 1'b1, 1'b0, 0, 16'hFFFE, 3, 1'b1);
        put(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b1);
        put(1'b1, 1'b0, 1'b1, 0, 0, 0, 1'b1);
        n_cmp++; if (tlat_a !== 32'd5) begin n_fail++; $display("FAIL wrap_lat: got %0d want 5", tlat_a); end
        n_cmp++; if (minl_a !== 16'd5 || maxl_a !== 16'd5) begin
            n_fail++; $display("FAIL wrap_minmax: got %0d/%0d want 5/5", minl_a, maxl_a);
        end
    endtask

    task automatic test_idle_body();
        do_reset();
        put(1'b1, 1'b0, 1'b0, 2, 0, 0, 1'b1);
        n_cmp++; if (err_a !== 1'b1) begin n_fail++; $display("FAIL body_err: got %b want 1", err_a); end
        n_cmp++; if (credit_a !== 4'b0100) begin n_fail++; $display("FAIL body_credit: got %b want 0100", credit_a); end
        idle(3);
        n_cmp++; if (err_a !== 1'b1) begin n_fail++; $display("FAIL body_sticky: got %b want 1", err_a); end
        n_cmp++; if (rec_a !== 32'd0 || drop_a !== 32'd0) begin
            n_fail++; $display("FAIL body_counts: got %0d/%0d want 0/0", rec_a, drop_a);
        end
    endtask

    task automatic test_warmup();
        int lats [5] = '{3, 7, 2, 9, 4};
        do_reset();
        idle(12);
        for (int i = 0; i < 5; i++) begin
            put(1'b1, 1'b1, 1'b1, i % NV, (now - lats[i]) & 16'hFFFF, i + 1, 1'b1);
            if (i == 3) begin
                n_cmp++; if (done_b !== 1'b0) begin n_fail++; $display("FAIL warm_done_early: got %b want 0", done_b); end
            end
        end
        n_cmp++; if (done_b !== 1'b1) begin n_fail++; $display("FAIL warm_done: got %b want 1", done_b); end
        n_cmp++; if (rec_b !== 32'd5) begin n_fail++; $display("FAIL warm_rec: got %0d want 5", rec_b); end
        n_cmp++; if (tlat_b !== 32'd15) begin n_fail++; $display("FAIL warm_tlat: got %0d want 15", tlat_b); end
        n_cmp++; if (thop_b !== 32'd12) begin n_fail++; $display("FAIL warm_thop: got %0d want 12", thop_b); end
        n_cmp++; if (minl_b !== 16'd2 || maxl_b !== 16'd9) begin
            n_fail++; $display("FAIL warm_minmax: got %0d/%0d want 2/9", minl_b, maxl_b);
        end
        n_cmp++; if (tlat_a !== 32'd25 || done_a !== 1'b1) begin
            n_fail++; $display("FAIL warm_w0: got tlat %0d done %b want 25 1", tlat_a, done_a);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        put(1'b1, 1'b1, 1'b0, 0, 1, 1, 1'b1);
        flit_valid = 1'b1; flit_head = 1'b0; flit_tail = 1'b1; flit_vc = 2'd0;
        rst = 1'b1;
        #1;
        n_cmp++; if (credit_a !== 4'b0 || rec_a !== 32'd0 || err_a !== 1'b0) begin
            n_fail++; $display("FAIL mid_rst_vals: got credit %b rec %0d err %b want 0000 0 0",
                               credit_a, rec_a, err_a);
        end
        n_cmp++; if (minl_a !== 16'hFFFF || tlat_a !== 32'd0) begin
            n_fail++; $display("FAIL mid_rst_stats: got min %h tlat %0d want ffff 0", minl_a, tlat_a);
        end
        @(posedge clk); #1;
        n_cmp++; if (credit_a !== 4'b0) begin n_fail++; $display("FAIL mid_rst_credit: got %b want 0000", credit_a); end
        @(negedge clk);
        flit_valid = 1'b0;
        model_clear();
        rst = 1'b0;
        put(1'b1, 1'b0, 1'b1, 0, 0, 0, 1'b1);
        n_cmp++; if (err_a !== 1'b1 || rec_a !== 32'd0) begin
            n_fail++; $display("FAIL mid_rst_body: got err %b rec %0d want 1 0", err_a, rec_a);
        end
    endtask

    task automatic test_random();
        longint sl, sh;
        int mn, mx;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            put($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 4,
                $urandom_range(0, NV - 1), $urandom_range(0, 65535), $urandom_range(0, 15),
                $urandom_range(0, 3) != 0);
            n_cmp++; if (credit_a !== m_credit || credit_b !== m_credit) begin
                n_fail++; $display("FAIL rnd_credit c%0d: got %b/%b want %b", c, credit_a, credit_b, m_credit);
            end
            n_cmp++; if (rec_a !== 32'(lat_q.size()) || rec_b !== 32'(lat_q.size())) begin
                n_fail++; $display("FAIL rnd_rec c%0d: got %0d/%0d want %0d", c, rec_a, rec_b, lat_q.size());
            end
            n_cmp++; if (drop_a !== 32'(m_drop) || drop_b !== 32'(m_drop)) begin
                n_fail++; $display("FAIL rnd_drop c%0d: got %0d/%0d want %0d", c, drop_a, drop_b, m_drop);
            end
            n_cmp++; if (err_a !== m_err || err_b !== m_err) begin
                n_fail++; $display("FAIL rnd_err c%0d: got %b/%b want %b", c, err_a, err_b, m_err);
            end
            n_cmp++; if (done_a !== (lat_q.size() >= 4) || done_b !== (lat_q.size() >= 5)) begin
                n_fail++; $display("FAIL rnd_done c%0d: got %b/%b for %0d packets", c, done_a, done_b,
                                   lat_q.size());
            end
            exp_stats(0, sl, sh, mn, mx);
            n_cmp++; if (tlat_a !== 32'(sl) || thop_a !== 32'(sh) || minl_a !== 16'(mn) || maxl_a !== 16'(mx)) begin
                n_fail++; $display("FAIL rnd_stats_w0 c%0d: got %0d %0d %0d %0d want %0d %0d %0d %0d", c,
                                   tlat_a, thop_a, minl_a, maxl_a, sl, sh, mn, mx);
            end
            exp_stats(2, sl, sh, mn, mx);
            n_cmp++; if (tlat_b !== 32'(sl) || thop_b !== 32'(sh) || minl_b !== 16'(mn) || maxl_b !== 16'(mx)) begin
                n_fail++; $display("FAIL rnd_stats_w2 c%0d: got %0d %0d %0d %0d want %0d %0d %0d %0d", c,
                                   tlat_b, thop_b, minl_b, maxl_b, sl, sh, mn, mx);
            end
        end
    endtask

    initial begin
        model_clear();
        @(negedge clk);
        test_reset();
        test_basic();
        test_drop();
        test_wrap();
        test_idle_body();
        test_warmup();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
